// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared bus defines and entry type for the fetch queue
`ifndef FETCH_QUEUE_DEFINES
`define FETCH_QUEUE_DEFINES
`define RstEnable   1'b1
`define RstDisable  1'b0
`define Stop        1'b1
`define NoStop      1'b0
`define ZeroWord    32'h0000_0000
`define InstAddrBus 31:0
`define InstBus     31:0
`endif

package fetch_queue_pkg;

  localparam int ENTRY_W = 96;

  typedef struct packed {
    logic [`InstAddrBus] pc;
    logic [`InstBus]     inst;
    logic [31:0]         excepttype;
  } fq_entry_t;

  function automatic fq_entry_t make_entry(logic [`InstAddrBus] pc,
                                           logic [`InstBus] inst,
                                           logic [31:0] excepttype);
    fq_entry_t e;
    e.pc         = pc;
    e.inst       = inst;
    e.excepttype = excepttype;
    return e;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch-side push and decode-side head signals
interface fetch_queue_if;
  logic                in_valid;
  logic [`InstAddrBus] in_pc;
  logic [`InstBus]     in_inst;
  logic [31:0]         in_excepttype;
  logic                stallreq_o;
  logic                id_valid;
  logic [`InstAddrBus] id_pc;
  logic [`InstBus]     id_inst;
  logic [31:0]         id_excepttype;

  modport master (
    output in_valid, in_pc, in_inst, in_excepttype,
    input  stallreq_o, id_valid, id_pc, id_inst, id_excepttype
  );

  modport slave (
    input  in_valid, in_pc, in_inst, in_excepttype,
    output stallreq_o, id_valid, id_pc, id_inst, id_excepttype
  );
endinterface

// File: rtl/fq_ram.sv
// rtl/fq_ram.sv - entry storage, synchronous write and asynchronous read
module fq_ram
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fq_entry_t     wdata,
  input  logic [AW-1:0] raddr,
  output fq_entry_t     rdata
);

  fq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction queue between fetch and decode
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       stall,
  input  logic             flush,
  output logic [CNT_W-1:0] count_o,
  fetch_queue_if.slave     bus
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CNT_W-1:0] count;
  logic             pop;
  logic             push;
  logic             full;
  fq_entry_t        head;

  // Only the decode stage's stall bit matters to this queue.
  logic unused_stall;
  assign unused_stall = ^{stall[5:3], stall[1:0]};

  assign full = (count == CNT_W'(DEPTH));
  assign pop  = bus.id_valid && (stall[2] == `NoStop);
  assign push = bus.in_valid && !flush && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst == `RstEnable) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  fq_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(make_entry(bus.in_pc, bus.in_inst, bus.in_excepttype)),
    .raddr(rd_ptr),
    .rdata(head)
  );

  // Stale storage is masked so an empty queue presents a nop bubble.
  assign bus.id_valid      = (count != '0);
  assign bus.id_pc         = bus.id_valid ? head.pc         : `ZeroWord;
  assign bus.id_inst       = bus.id_valid ? head.inst       : `ZeroWord;
  assign bus.id_excepttype = bus.id_valid ? head.excepttype : `ZeroWord;
  assign bus.stallreq_o    = full && !pop;
  assign count_o           = count;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

  logic       clk;
  logic       rst;
  logic [5:0] stall;
  logic       flush;
  logic [2:0] count_o;
  int         checks;
  int         errors;

  fetch_queue_if bus ();

  fetch_queue #(
    .DEPTH(4),
    .CNT_W(3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .stall  (stall),
    .flush  (flush),
    .count_o(count_o),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ex);
    bus.in_valid      = v;
    bus.in_pc         = pc;
    bus.in_inst       = pc ^ 32'h5A5A_0000;
    bus.in_excepttype = ex;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    stall  = 6'b0;
    flush  = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    cyc();
    cyc();
    chk("rst_valid", bus.id_valid, 32'd0);
    chk("rst_inst", bus.id_inst, 32'd0);
    chk("rst_pc", bus.id_pc, 32'd0);
    chk("rst_exc", bus.id_excepttype, 32'd0);
    chk("rst_count", count_o, 32'd0);
    chk("rst_stallreq", bus.stallreq_o, 32'd0);
    rst = 1'b0;

    // Streaming with no stall: each entry one cycle after its push
    drive(1'b1, 32'hBFC0_0000, 32'h0);
    cyc();
    chk("str0_pc", bus.id_pc, 32'hBFC0_0000);
    chk("str0_inst", bus.id_inst, 32'hE59A_0000);
    chk("str0_count", count_o, 32'd1);
    drive(1'b1, 32'hBFC0_0004, 32'h0);
    cyc();
    chk("str1_pc", bus.id_pc, 32'hBFC0_0004);
    chk("str1_count", count_o, 32'd1);
    drive(1'b1, 32'hBFC0_0008, 32'h0);
    cyc();
    chk("str2_pc", bus.id_pc, 32'hBFC0_0008);
    chk("str2_count", count_o, 32'd1);
    drive(1'b0, 32'h0, 32'h0);
    cyc();
    chk("str_drain_count", count_o, 32'd0);
    chk("str_drain_valid", bus.id_valid, 32'd0);
    chk("str_drain_pc", bus.id_pc, 32'd0);

    // Fill under decode stall
    stall = 6'b000100;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(i * 4), 32'h0);
      cyc();
      chk("fill_count", count_o, 32'(i + 1));
    end
    chk("full_stallreq", bus.stallreq_o, 32'd1);
    drive(1'b1, 32'h110, 32'h0);
    cyc();
    chk("ignored_count", count_o, 32'd4);
    chk("ignored_head", bus.id_pc, 32'h100);

    // Full with pop in same cycle: push accepted
    stall = 6'b0;
    #1;
    chk("full_pop_stallreq", bus.stallreq_o, 32'd0);
    cyc();
    chk("full_pop_count", count_o, 32'd4);
    chk("full_pop_head", bus.id_pc, 32'h104);
    drive(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", bus.id_pc, 32'h104 + 32'(i * 4));
      cyc();
    end
    chk("drain_empty", count_o, 32'd0);

    // Flush discards queued entries and the simultaneous push
    stall = 6'b000100;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h200 + 32'(i * 4), 32'h0);
      cyc();
    end
    chk("preflush_count", count_o, 32'd3);
    drive(1'b1, 32'h20C, 32'h0);
    flush = 1'b1;
    cyc();
    chk("flush_count", count_o, 32'd0);
    chk("flush_valid", bus.id_valid, 32'd0);
    chk("flush_pc", bus.id_pc, 32'd0);
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    cyc();
    chk("postflush_count", count_o, 32'd0);

    // Exception vector carried with its pc
    drive(1'b1, 32'h0000_0102, 32'h0001_0000);
    cyc();
    chk("exc_pc", bus.id_pc, 32'h0000_0102);
    chk("exc_type", bus.id_excepttype, 32'h0001_0000);
    chk("exc_inst", bus.id_inst, 32'h5A5A_0102);

    // Mid-operation reset beats a push
    drive(1'b1, 32'h300, 32'h0);
    rst = 1'b1;
    cyc();
    chk("midrst_count", count_o, 32'd0);
    chk("midrst_valid", bus.id_valid, 32'd0);
    chk("midrst_exc", bus.id_excepttype, 32'd0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two, at least 2.
REQ-002 Parameter CNT_W, default 3, occupancy counter width; SHALL equal log2(DEPTH)+1.
REQ-003 Port clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  in  1  synchronous, active-high reset; asserted value is `RstEnable.
REQ-005 Port stall  in  6  pipeline stall vector; stall[2]==`Stop means decode does not consume this cycle.
REQ-006 Port flush  in  1  exception/eret flush; discards all queued entries.
REQ-007 Port in_valid  in  1  a fetched instruction is presented this cycle.
REQ-008 Port in_pc  in  32  fetch address, driven by icache_pc of the fetch stage.
REQ-009 Port in_inst  in  32  instruction word returned for in_pc.
REQ-010 Port in_excepttype  in  32  fetch exception vector; bit 16 = fetch address-error.
REQ-011 Port stallreq_o  out  1  request to stall fetch because the queue cannot accept.
REQ-012 Port id_valid  out  1  head entry is valid for decode.
REQ-013 Port id_pc  out  32  head entry pc.
REQ-014 Port id_inst  out  32  head entry instruction.
REQ-015 Port id_excepttype  out  32  head entry exception vector.
REQ-016 Port count_o  out  CNT_W  current occupancy, 0..DEPTH.

Function
REQ-017 pop SHALL be id_valid && stall[2]==`NoStop.
REQ-018 push SHALL be in_valid && !flush && (count<DEPTH || pop).
REQ-019 Queue SHALL be FIFO; entries SHALL leave in push order with pc, inst, excepttype unmodified.
REQ-020 id_valid SHALL be (count!=0); id_pc, id_inst, id_excepttype SHALL show the head entry combinationally from registered storage.
REQ-021 When count==0, id_pc, id_inst, id_excepttype SHALL be `ZeroWord (bubble = nop).
REQ-022 Latency: a push into an empty queue SHALL appear at id_* in the next cycle; no same-cycle bypass.
REQ-023 count SHALL change by +1 on push-only, -1 on pop-only, 0 on push+pop or neither.
REQ-024 Read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-025 Full with simultaneous pop SHALL accept the push; count stays DEPTH.
REQ-026 stallreq_o SHALL be (count==DEPTH) && !pop; fetch holds in_* while it is high.
REQ-027 in_valid while full and no pop SHALL be ignored without state change (data remains upstream under stall).
REQ-028 Empty queue: pop SHALL never occur; pointers unchanged.
REQ-029 flush SHALL, at the next edge, set count, both pointers to 0, overriding push and pop in that cycle.
REQ-030 flush SHALL take priority over stall; after flush id_valid SHALL be 0 for at least one cycle.
REQ-031 excepttype SHALL be carried opaquely; entries with nonzero excepttype SHALL be queued and popped like any other.

Reset
REQ-032 rst SHALL clear count, read pointer, write pointer to 0 at the next clk edge and take priority over flush, push, pop.
REQ-033 During and after reset: id_valid=0, id_pc=id_inst=id_excepttype=`ZeroWord, stallreq_o=0, count_o=0.
REQ-034 Storage array contents need not be reset; they SHALL never be visible while count==0.
REQ-035 rst asserted mid-operation SHALL discard all entries exactly as flush does.

Structure
REQ-036 Bus widths and constants (`InstAddrBus, `InstBus, `ZeroWord, `RstEnable, `Stop, `NoStop) SHALL come from the shared defines file; no local redefinition.
REQ-037 Entry storage SHALL be a sub-module fq_ram (DEPTH x 96-bit, one synchronous write port, one asynchronous read port); pointer/count control stays in fetch_queue.

Verification
REQ-038 Reset then idle: rst=1 two cycles -> id_valid=0, id_inst=0, count_o=0, stallreq_o=0.
REQ-039 Push pc 0xBFC00000/0xBFC00004/0xBFC00008, stall[2]=0 -> each appears one cycle after push, in order, count_o never exceeds 1.
REQ-040 stall[2]=1, push 5 entries pc 0x100..0x110 -> count_o=4 after 4 pushes, stallreq_o=1, fifth ignored; release stall -> 0x100..0x10C popped in order.
REQ-041 Full queue, stall[2]=0 and in_valid=1 same cycle -> pop 0x100 and push accepted, count_o stays 4, stallreq_o=0.
REQ-042 3 entries queued, flush=1 with in_valid=1 -> next cycle count_o=0, id_valid=0; pushed entry discarded.
REQ-043 Push pc 0x00000102 with in_excepttype 0x00010000 -> id_excepttype 0x00010000 delivered with id_pc 0x00000102.
